// File: rtl/arm_pkg.sv
// Shared ARM control definitions: condition codes, NZCV flag bit positions
// and the meaning of the decoder's FlagW bits.
package arm_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // FlagW[1] enables the N/Z pair, FlagW[0] enables the C/V pair.
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_unit_if.sv
// Decoder/ALU/write-port signals around the conditional-execution unit.
interface cond_unit_if;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       Stall;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic [3:0] Flags;
  logic       Carry;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, Stall,
    input  PCSrc, RegWrite, MemWrite, CondEx, Flags, Carry
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, Stall,
    output PCSrc, RegWrite, MemWrite, CondEx, Flags, Carry
  );
endinterface

// File: rtl/cond_unit_check.sv
// Combinational condition evaluator: instruction condition field against
// the stored NZCV flags. Shared with the pipelined datapath.
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v, ge;

  assign n  = Flags[FLAG_N];
  assign z  = Flags[FLAG_Z];
  assign c  = Flags[FLAG_C];
  assign v  = Flags[FLAG_V];
  assign ge = (n == v);

  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = ge;
      COND_LT: CondEx = ~ge;
      COND_GT: CondEx = ~z & ge;
      COND_LE: CondEx = z | ~ge;
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;   // NV: reserved, never executes
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: holds NZCV, evaluates the condition field and
// gates the decoder's write enables; stalls freeze flags and block writes.
module cond_unit
  import arm_pkg::*;
#(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic  CLK,
  input  logic  RESET,
  cond_unit_if.slave bus
);

  logic [3:0] flags_q;
  logic       cond_ex;
  logic       commit;

  cond_check u_cond_check (
    .Cond   (bus.Cond),
    .Flags  (flags_q),
    .CondEx (cond_ex)
  );

  // An instruction only takes effect when its condition passes and it is not held.
  assign commit = cond_ex & ~bus.Stall;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      flags_q <= FLAG_RESET;
    end else begin
      if (commit && bus.FlagW[FLAGW_NZ]) begin
        flags_q[FLAG_N] <= bus.ALUFlags[FLAG_N];
        flags_q[FLAG_Z] <= bus.ALUFlags[FLAG_Z];
      end
      if (commit && bus.FlagW[FLAGW_CV]) begin
        flags_q[FLAG_C] <= bus.ALUFlags[FLAG_C];
        flags_q[FLAG_V] <= bus.ALUFlags[FLAG_V];
      end
    end
  end

  assign bus.CondEx   = cond_ex;
  assign bus.PCSrc    = bus.PCS & commit;
  assign bus.RegWrite = bus.RegW & ~bus.NoWrite & commit;
  assign bus.MemWrite = bus.MemW & commit;
  assign bus.Flags    = flags_q;
  assign bus.Carry    = flags_q[FLAG_C];

endmodule
